// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: operation codes, the registered
// outcome flags and immediate sign extension.
package bru_pkg;

    localparam int BRU_AW_MAX = 64;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_JAL  = 4'd1,
        BR_JALR = 4'd2,
        BR_BEQ  = 4'd3,
        BR_BNE  = 4'd4,
        BR_BLT  = 4'd5,
        BR_BGE  = 4'd6,
        BR_BLTU = 4'd7,
        BR_BGEU = 4'd8
    } bru_op_e;

    // Addresses are held next to this record in the top, because their width
    // follows the ADDR_W parameter of the instance.
    typedef struct packed {
        logic taken;
        logic mispredict;
        logic misalign;
        logic illegal;
    } bru_res_t;

    function automatic logic [BRU_AW_MAX-1:0] sext_imm(input logic [BRU_AW_MAX-1:0] imm,
                                                       input int imm_w);
        logic [BRU_AW_MAX-1:0] r;
        r = imm;
        for (int i = 0; i < BRU_AW_MAX; i++) begin
            if (i >= imm_w) r[i] = imm[imm_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/bru_compare.sv
// Branch condition evaluation: decodes the op code and compares the operands.
module bru_compare
    import bru_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              cond_true,
    output logic              is_jump,
    output logic              is_defined
);

    logic eq, lt_s, lt_u;

    assign eq   = (src1 == src2);
    assign lt_s = ($signed(src1) < $signed(src2));
    assign lt_u = (src1 < src2);

    always_comb begin
        cond_true  = 1'b0;
        is_jump    = 1'b0;
        is_defined = 1'b1;
        case (ctrl)
            CTRL_W'(BR_NONE): ;
            CTRL_W'(BR_JAL),
            CTRL_W'(BR_JALR): is_jump = 1'b1;
            CTRL_W'(BR_BEQ):  cond_true = eq;
            CTRL_W'(BR_BNE):  cond_true = !eq;
            CTRL_W'(BR_BLT):  cond_true = lt_s;
            CTRL_W'(BR_BGE):  cond_true = !lt_s;
            CTRL_W'(BR_BLTU): cond_true = lt_u;
            CTRL_W'(BR_BGEU): cond_true = !lt_u;
            default:          is_defined = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution with a one-entry valid/ready output register.
// Define BRU_STATS_EN to add saturating branch/taken/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int IMM_W     = 21,
    parameter int BYTE_ADDR = 1,
    parameter int CTRL_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              system_stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_branch,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              mispredict,
    output logic              misalign,
    output logic              illegal_op
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_taken,
    output logic [31:0]       stat_mispred
`endif
);

    localparam logic [ADDR_W-1:0] STEP = (BYTE_ADDR != 0) ? ADDR_W'(4) : ADDR_W'(1);

    logic [ADDR_W-1:0] sext, off, fall_thru, jalr_sum, target;
    logic              cond_true, is_jump, is_defined, is_jalr, taken, accept;
    bru_res_t          flags_d, flags_q;

    bru_compare #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_cmp (
        .ctrl       (ctrl_branch),
        .src1       (src1),
        .src2       (src2),
        .cond_true  (cond_true),
        .is_jump    (is_jump),
        .is_defined (is_defined)
    );

    assign sext      = ADDR_W'(sext_imm(BRU_AW_MAX'(immediate), IMM_W));
    // Word PCs count instructions, so the byte offset drops its two low bits.
    assign off       = (BYTE_ADDR != 0) ? sext : {sext[ADDR_W-1], sext[ADDR_W-1], sext[ADDR_W-1:2]};
    assign fall_thru = pc + STEP;
    assign is_jalr   = (ctrl_branch == CTRL_W'(BR_JALR));
    assign jalr_sum  = ADDR_W'(src1) + off;
    assign target    = is_jalr ? {jalr_sum[ADDR_W-1:1], 1'b0} : pc + off;
    assign taken     = is_jump | cond_true;

    always_comb begin
        flags_d.taken      = taken;
        flags_d.mispredict = is_defined & ((taken != pred_taken) | (taken & (target != pred_target)));
        flags_d.misalign   = taken & (BYTE_ADDR != 0) & (target[1:0] != 2'b00);
        flags_d.illegal    = !is_defined;
    end

    assign in_ready = !system_stall & (!res_valid | res_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            flags_q   <= '0;
            next_pc   <= '0;
            link_addr <= '0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (!system_stall) begin
            if (accept) begin
                res_valid <= 1'b1;
                flags_q   <= flags_d;
                next_pc   <= taken ? target : fall_thru;
                link_addr <= fall_thru;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign branch_taken = flags_q.taken;
    assign mispredict   = flags_q.mispredict;
    assign misalign     = flags_q.misalign;
    assign illegal_op   = flags_q.illegal;

`ifdef BRU_STATS_EN
    logic handshake;
    assign handshake = res_valid & res_ready & !system_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_taken    <= '0;
            stat_mispred  <= '0;
        end else if (handshake) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (flags_q.taken && stat_taken != '1) stat_taken <= stat_taken + 32'd1;
            if (flags_q.mispredict && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: byte-PC and word-PC instances share stimulus; expected results
// come from an arithmetic reference model or hand-derived constants.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset, flush, system_stall, in_valid, res_ready, pred_taken;
    logic [3:0]  ctrl_branch;
    logic [31:0] src1, src2, pc, pred_target;
    logic [20:0] immediate;

    logic        b_in_ready, b_res_valid, b_taken, b_mis, b_mal, b_ill;
    logic [31:0] b_next_pc, b_link;
    logic        w_in_ready, w_res_valid, w_taken, w_mis, w_mal, w_ill;
    logic [31:0] w_next_pc, w_link;
`ifdef BRU_STATS_EN
    logic [31:0] b_sb, b_st, b_sm, w_sb, w_st, w_sm;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.BYTE_ADDR(1)) u_byte (
        .clk(clk), .reset(reset), .flush(flush), .system_stall(system_stall),
        .in_valid(in_valid), .in_ready(b_in_ready), .ctrl_branch(ctrl_branch),
        .src1(src1), .src2(src2), .immediate(immediate), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(b_res_valid), .res_ready(res_ready), .branch_taken(b_taken),
        .next_pc(b_next_pc), .link_addr(b_link), .mispredict(b_mis),
        .misalign(b_mal), .illegal_op(b_ill)
`ifdef BRU_STATS_EN
        , .stat_branches(b_sb), .stat_taken(b_st), .stat_mispred(b_sm)
`endif
    );

    branch_resolve_unit #(.BYTE_ADDR(0)) u_word (
        .clk(clk), .reset(reset), .flush(flush), .system_stall(system_stall),
        .in_valid(in_valid), .in_ready(w_in_ready), .ctrl_branch(ctrl_branch),
        .src1(src1), .src2(src2), .immediate(immediate), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(w_res_valid), .res_ready(res_ready), .branch_taken(w_taken),
        .next_pc(w_next_pc), .link_addr(w_link), .mispredict(w_mis),
        .misalign(w_mal), .illegal_op(w_ill)
`ifdef BRU_STATS_EN
        , .stat_branches(w_sb), .stat_taken(w_st), .stat_mispred(w_sm)
`endif
    );

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] s1, s2, pc, ptgt;
        logic [20:0] imm;
        logic        pt;
    } stim_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] nxt, link;
        logic        mis, mal, ill;
    } exp_t;

    typedef struct packed {
        exp_t b;
        exp_t w;
    } pair_t;

    pair_t sbq[$];
    int    n_checks = 0;
    int    n_err    = 0;
    logic  stuck    = 1'b0;
    logic  rnd      = 1'b0;

    function automatic exp_t model(input stim_t s, input bit bm);
        exp_t        e;
        longint      sx, off;
        logic [31:0] tgt;
        logic        tk;
        sx  = s.imm[20] ? longint'(s.imm) - (longint'(1) << 21) : longint'(s.imm);
        off = bm ? sx : ((sx >= 0) ? sx / 4 : -((-sx + 3) / 4));
        e.link = s.pc + (bm ? 32'd4 : 32'd1);
        tgt = 32'(longint'(s.pc) + off);
        tk = 1'b0;
        e.ill = 1'b0;
        case (s.ctrl)
            4'd0: tk = 1'b0;
            4'd1: tk = 1'b1;
            4'd2: begin tk = 1'b1; tgt = 32'(longint'(s.s1) + off); tgt[0] = 1'b0; end
            4'd3: tk = (s.s1 == s.s2);
            4'd4: tk = (s.s1 != s.s2);
            4'd5: tk = ($signed(s.s1) <  $signed(s.s2));
            4'd6: tk = ($signed(s.s1) >= $signed(s.s2));
            4'd7: tk = (s.s1 <  s.s2);
            4'd8: tk = (s.s1 >= s.s2);
            default: e.ill = 1'b1;
        endcase
        e.taken = tk;
        e.nxt   = tk ? tgt : e.link;
        e.mis   = !e.ill && ((tk != s.pt) || (tk && (tgt != s.ptgt)));
        e.mal   = bm && tk && (tgt[1:0] != 2'b00);
        return e;
    endfunction

    function automatic stim_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [20:0] im, input logic [31:0] p,
                                 input logic pt, input logic [31:0] pg);
        stim_t s;
        s.ctrl = c; s.s1 = a; s.s2 = b; s.imm = im; s.pc = p; s.pt = pt; s.ptgt = pg;
        return s;
    endfunction

    function automatic exp_t ex(input logic tk, input logic [31:0] n, input logic [31:0] l,
                                input logic m, input logic a, input logic i);
        exp_t e;
        e.taken = tk; e.nxt = n; e.link = l; e.mis = m; e.mal = a; e.ill = i;
        return e;
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input string t, input exp_t e, input logic tk, input logic [31:0] np,
                           input logic [31:0] la, input logic mp, input logic ma, input logic il);
        chk({t, ".taken"},      tk, e.taken);
        chk({t, ".next_pc"},    np, e.nxt);
        chk({t, ".link_addr"},  la, e.link);
        chk({t, ".mispredict"}, mp, e.mis);
        chk({t, ".misalign"},   ma, e.mal);
        chk({t, ".illegal_op"}, il, e.ill);
    endtask

    logic        was_reset = 1'b0;
    logic        stuck_seen = 1'b0;
    logic [31:0] mb_br = 0, mb_tk = 0, mb_mp = 0, mw_br = 0, mw_tk = 0, mw_mp = 0;

    always @(negedge clk) begin
        if (reset) begin
            was_reset = 1'b1;
            mb_br = 0; mb_tk = 0; mb_mp = 0; mw_br = 0; mw_tk = 0; mw_mp = 0;
        end else begin
            if (was_reset) begin
                cmp_out("reset.b", ex(0, 0, 0, 0, 0, 0), b_taken, b_next_pc, b_link, b_mis, b_mal, b_ill);
                cmp_out("reset.w", ex(0, 0, 0, 0, 0, 0), w_taken, w_next_pc, w_link, w_mis, w_mal, w_ill);
                was_reset = 1'b0;
            end
            if (stuck && !stuck_seen) begin
                chk("issue_timeout", stuck, 1'b0);
                stuck_seen = 1'b1;
            end
            chk("b.in_ready", b_in_ready, !system_stall && (sbq.size() == 0 || res_ready));
            chk("w.in_ready", w_in_ready, !system_stall && (sbq.size() == 0 || res_ready));
            chk("b.res_valid", b_res_valid, sbq.size() != 0);
            chk("w.res_valid", w_res_valid, sbq.size() != 0);
            if (sbq.size() != 0) begin
                if (b_res_valid) cmp_out("b", sbq[0].b, b_taken, b_next_pc, b_link, b_mis, b_mal, b_ill);
                if (w_res_valid) cmp_out("w", sbq[0].w, w_taken, w_next_pc, w_link, w_mis, w_mal, w_ill);
            end
`ifdef BRU_STATS_EN
            chk("b.stat_branches", b_sb, mb_br);
            chk("b.stat_taken",    b_st, mb_tk);
            chk("b.stat_mispred",  b_sm, mb_mp);
            chk("w.stat_branches", w_sb, mw_br);
            chk("w.stat_taken",    w_st, mw_tk);
            chk("w.stat_mispred",  w_sm, mw_mp);
`endif
            if (sbq.size() != 0 && res_ready && !system_stall) begin
                mb_br++; mw_br++;
                if (sbq[0].b.taken) mb_tk++;
                if (sbq[0].b.mis)   mb_mp++;
                if (sbq[0].w.taken) mw_tk++;
                if (sbq[0].w.mis)   mw_mp++;
                void'(sbq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        if (flush || reset) sbq.delete();
        flush = 1'b0;
        if (rnd) begin
            res_ready    = ($urandom_range(0, 3) != 0);
            system_stall = ($urandom_range(0, 9) == 0);
            flush        = ($urandom_range(0, 24) == 0);
        end
    endtask

    task automatic drive(input stim_t s);
        ctrl_branch = s.ctrl; src1 = s.s1; src2 = s.s2; immediate = s.imm;
        pc = s.pc; pred_taken = s.pt; pred_target = s.ptgt;
        in_valid = 1'b1;
    endtask

    task automatic issue(input stim_t s, input bit ob, input exp_t cb, input bit ow, input exp_t cw);
        pair_t p;
        bit    ok, fl;
        int    n;
        p.b = ob ? cb : model(s, 1'b1);
        p.w = ow ? cw : model(s, 1'b0);
        drive(s);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 60) begin
            @(negedge clk);
            ok = b_in_ready;
            fl = flush;
            cycle();
            if (ok && !fl) sbq.push_back(p);
            n++;
        end
        in_valid = 1'b0;
        if (!ok) stuck = 1'b1;
    endtask

    task automatic issue_m(input stim_t s);
        issue(s, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        stim_t s;
        reset = 1'b1; flush = 1'b0; system_stall = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        ctrl_branch = '0; src1 = '0; src2 = '0; immediate = '0; pc = '0;
        pred_taken = 1'b0; pred_target = '0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // plan vectors with hand-derived results
        issue(mk(4'd5, 32'hFFFF_FFFF, 32'd1, 21'h1F_FFF8, 32'h100, 1'b0, 32'h0),
              1'b1, ex(1, 32'hF8, 32'h104, 1, 0, 0), 1'b0, '0);
        issue(mk(4'd7, 32'hFFFF_FFFF, 32'd1, 21'h1F_FFF8, 32'h100, 1'b0, 32'h0),
              1'b1, ex(0, 32'h104, 32'h104, 0, 0, 0), 1'b0, '0);
        issue(mk(4'd2, 32'h2003, 32'd0, 21'd4, 32'h300, 1'b1, 32'h2006),
              1'b1, ex(1, 32'h2006, 32'h304, 0, 1, 0), 1'b0, '0);
        issue(mk(4'd3, 32'd5, 32'd5, 21'h20, 32'h10, 1'b1, 32'h18),
              1'b0, '0, 1'b1, ex(1, 32'h18, 32'h11, 0, 0, 0));
        issue(mk(4'd3, 32'd5, 32'd6, 21'h20, 32'h10, 1'b0, 32'h0),
              1'b0, '0, 1'b1, ex(0, 32'h11, 32'h11, 0, 0, 0));
        issue(mk(4'hF, 32'd1, 32'd2, 21'h40, 32'h500, 1'b1, 32'h540),
              1'b1, ex(0, 32'h504, 32'h504, 0, 0, 1), 1'b0, '0);
        repeat (2) cycle();

        // backpressure: result held three cycles while a second uop waits
        issue_m(mk(4'd1, 32'd0, 32'd0, 21'h80, 32'h4000, 1'b1, 32'h4080));
        res_ready = 1'b0;
        s = mk(4'd4, 32'd9, 32'd3, 21'h1F_FFF0, 32'h5000, 1'b0, 32'h0);
        drive(s);
        repeat (3) cycle();
        res_ready = 1'b1;
        issue_m(s);
        repeat (2) cycle();

        // stall together with flush drops the pending result
        res_ready = 1'b0;
        issue_m(mk(4'd6, 32'd3, 32'd3, 21'h10, 32'h6000, 1'b1, 32'h6010));
        system_stall = 1'b1;
        flush = 1'b1;
        cycle();
        system_stall = 1'b0;
        res_ready = 1'b1;
        repeat (2) cycle();

        // stall alone holds the result and blocks acceptance
        res_ready = 1'b0;
        issue_m(mk(4'd8, 32'd1, 32'd2, 21'h10, 32'h7000, 1'b0, 32'h0));
        res_ready = 1'b1;
        system_stall = 1'b1;
        s = mk(4'd1, 32'd0, 32'd0, 21'h1F_FFFC, 32'h7100, 1'b1, 32'h70FC);
        drive(s);
        repeat (2) cycle();
        system_stall = 1'b0;
        issue_m(s);
        repeat (2) cycle();

        // five handshakes: three taken, one mispredicted (byte PCs), then reset
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        issue_m(mk(4'd1, 32'd0, 32'd0, 21'h10, 32'h1000, 1'b1, 32'h1010));
        issue_m(mk(4'd3, 32'd7, 32'd7, 21'h8,  32'h2000, 1'b1, 32'h2008));
        issue_m(mk(4'd4, 32'd1, 32'd2, 21'hC,  32'h3000, 1'b1, 32'h300C));
        issue_m(mk(4'd5, 32'd5, 32'd3, 21'h8,  32'h3100, 1'b0, 32'h0));
        issue_m(mk(4'd6, 32'hFFFF_FFFF, 32'd0, 21'h8, 32'h3200, 1'b1, 32'h3208));
        repeat (3) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // randomized traffic with random backpressure, stalls and flushes
        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            s.ctrl = 4'($urandom_range(0, 9));
            if (s.ctrl == 4'd9) s.ctrl = 4'($urandom_range(9, 15));
            s.s1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            s.s2   = ($urandom_range(0, 2) == 0) ? s.s1 : $urandom;
            s.imm  = 21'($urandom);
            s.pc   = $urandom;
            s.pt   = 1'($urandom_range(0, 1));
            s.ptgt = $urandom;
            if ($urandom_range(0, 1) == 1) s.ptgt = model(s, 1'b1).nxt;
            issue_m(s);
            if ($urandom_range(0, 4) == 0) cycle();
        end
        rnd = 1'b0;
        res_ready = 1'b1;
        system_stall = 1'b0;
        flush = 1'b0;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
